// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB full-speed transmitter.
// Holds the tx_packet command encoding, the FSM state enum, the encoder
// line-mode enum, PID/SYNC byte constants and the CRC16 parameters.
package usb_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_pkt_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC, ST_EOP, ST_EOP_J
    } tx_state_e;

    // What the encoder drives for the next bit time.
    typedef enum logic [1:0] {
        LINE_DATA = 2'd0,
        LINE_SE0  = 2'd1,
        LINE_J    = 2'd2
    } line_mode_e;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [7:0]  PID_DATA1  = 8'h4B;
    localparam logic [7:0]  PID_ACK    = 8'hD2;
    localparam logic [7:0]  PID_NAK    = 8'h5A;
    localparam logic [7:0]  PID_STALL  = 8'h1E;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [7:0] pid_byte(input logic [2:0] pkt);
        case (pkt)
            PKT_DATA0: return PID_DATA0;
            PKT_DATA1: return PID_DATA1;
            PKT_ACK:   return PID_ACK;
            PKT_NAK:   return PID_NAK;
            PKT_STALL: return PID_STALL;
            default:   return 8'h00;
        endcase
    endfunction

    function automatic logic is_data(input logic [2:0] pkt);
        return (pkt == PKT_DATA0) || (pkt == PKT_DATA1);
    endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: bit-time pacing, bit stuffing, NRZI and SE0/J line driver.
//   clk, rst      clock, async active-high reset (lines go to J)
//   valid_i       FSM has a bit (or line state) ready for the next bit time
//   bit_i         data bit, used when mode_i is LINE_DATA
//   mode_i        LINE_DATA / LINE_SE0 / LINE_J
//   stuff_en_i    count ones and stuff after six (PID, DATA, CRC)
//   consumed_o    the presented bit was taken this cycle (not on stuffed bits)
//   bit_end_o     last cycle of the bit currently on the line
//   dplus_o/dminus_o registered line outputs
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic       bit_i,
    input  logic [1:0] mode_i,
    input  logic       stuff_en_i,
    output logic       consumed_o,
    output logic       bit_end_o,
    output logic       dplus_o,
    output logic       dminus_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ones_q, ones_d;
    logic          dp_q, dp_d, dm_q, dm_d;
    logic          load, stuff_now, tx_bit;

    always_comb begin
        bit_end_o  = busy_q && (cnt_q == LAST);
        // A new bit goes on the line either from idle or exactly at a bit boundary.
        load       = valid_i && (!busy_q || bit_end_o);
        stuff_now  = stuff_en_i && (mode_i == LINE_DATA) && (ones_q == 3'd6);
        consumed_o = load && !stuff_now;
        tx_bit     = stuff_now ? 1'b0 : bit_i;

        busy_d = busy_q;
        cnt_d  = cnt_q;
        ones_d = ones_q;
        dp_d   = dp_q;
        dm_d   = dm_q;
        if (busy_q)    cnt_d  = cnt_q + 1'b1;
        if (bit_end_o) busy_d = 1'b0;
        if (load) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            case (mode_i)
                LINE_SE0: begin dp_d = 1'b0; dm_d = 1'b0; ones_d = '0; end
                LINE_J:   begin dp_d = 1'b1; dm_d = 1'b0; ones_d = '0; end
                default: begin
                    // NRZI: a 0 swaps J/K, a 1 holds the line.
                    if (!tx_bit) begin
                        dp_d = ~dp_q;
                        dm_d = dp_q;
                    end
                    ones_d = (stuff_en_i && tx_bit) ? ones_q + 3'd1 : 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            ones_q <= '0;
            dp_q   <= 1'b1;
            dm_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
            dp_q   <= dp_d;
            dm_q   <= dm_d;
        end
    end

    assign dplus_o  = dp_q;
    assign dminus_o = dm_q;

endmodule

// File: rtl/usb_tx.sv
// usb_tx: USB full-speed packet transmitter (SYNC, PID, payload, CRC16, EOP).
//   clk, rst              clock, async active-high reset
//   tx_packet             command (1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL)
//   buffer_occupancy      payload bytes waiting in the data buffer
//   tx_packet_data        buffer byte, valid the cycle after a fetch pulse
//   get_tx_packet_data    one-cycle fetch pulse for the next payload byte
//   tx_transfer_active    high while a packet is in flight
//   tx_error              one-cycle pulse on a rejected command
//   dplus_out, dminus_out USB line outputs
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam logic [6:0] MAXB = 7'(MAX_BYTES);

    tx_state_e   state_q, state_d;
    logic [2:0]  pkt_q, pkt_d;
    logic [6:0]  left_q, left_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] crc_q, crc_d;
    logic        jsent_q, jsent_d;
    logic        get_q, get_d, get_dly_q;
    logic        err_q, err_d;
    logic [7:0]  byte_q, data_cur, pid_w;

    logic       enc_valid, enc_bit, enc_stuff, consumed, bit_end;
    logic [1:0] enc_mode;

    usb_tx_encoder #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_enc (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (enc_valid),
        .bit_i      (enc_bit),
        .mode_i     (enc_mode),
        .stuff_en_i (enc_stuff),
        .consumed_o (consumed),
        .bit_end_o  (bit_end),
        .dplus_o    (dplus_out),
        .dminus_o   (dminus_out)
    );

    always_comb begin
        // Bypass so a byte arriving in the same cycle as its first bit's load
        // is still used (matters only for very small CLKS_PER_BIT).
        data_cur  = get_dly_q ? tx_packet_data : byte_q;
        pid_w     = pid_byte(pkt_q);
        enc_valid = (state_q != ST_IDLE) && !(state_q == ST_EOP_J && jsent_q);
        enc_bit   = 1'b0;
        enc_mode  = LINE_DATA;
        enc_stuff = 1'b0;

        state_d = state_q;
        pkt_d   = pkt_q;
        left_d  = left_q;
        bit_d   = bit_q;
        crc_d   = crc_q;
        jsent_d = jsent_q;
        get_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_packet > 3'd5 || (is_data(tx_packet) && buffer_occupancy > MAXB)) begin
                    err_d = 1'b1;
                end else if (tx_packet != 3'd0) begin
                    state_d = ST_SYNC;
                    pkt_d   = tx_packet;
                    left_d  = is_data(tx_packet) ? buffer_occupancy : 7'd0;
                    bit_d   = '0;
                    crc_d   = CRC16_INIT;
                    jsent_d = 1'b0;
                end
            end
            ST_SYNC: begin
                enc_bit = SYNC_BYTE[bit_q[2:0]];
                if (consumed) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        bit_d   = '0;
                        state_d = ST_PID;
                    end
                end
            end
            ST_PID: begin
                enc_bit   = pid_w[bit_q[2:0]];
                enc_stuff = 1'b1;
                if (consumed) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        bit_d = '0;
                        if (!is_data(pkt_q))   state_d = ST_EOP;
                        else if (left_q == 0)  state_d = ST_CRC;
                        else begin
                            state_d = ST_DATA;
                            get_d   = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                enc_bit   = data_cur[bit_q[2:0]];
                enc_stuff = 1'b1;
                if (consumed) begin
                    crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ enc_bit) ? CRC16_POLY : 16'h0000);
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        bit_d  = '0;
                        left_d = left_q - 7'd1;
                        if (left_q == 7'd1) state_d = ST_CRC;
                        else                get_d   = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                enc_bit   = ~crc_q[15];
                enc_stuff = 1'b1;
                if (consumed) begin
                    crc_d = {crc_q[14:0], 1'b0};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        bit_d   = '0;
                        state_d = ST_EOP;
                    end
                end
            end
            ST_EOP: begin
                enc_mode = LINE_SE0;
                if (consumed) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd1) begin
                        bit_d   = '0;
                        state_d = ST_EOP_J;
                    end
                end
            end
            ST_EOP_J: begin
                enc_mode = LINE_J;
                if (consumed) jsent_d = 1'b1;
                // The packet ends when the J bit itself has run its full time.
                if (jsent_q && bit_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pkt_q     <= '0;
            left_q    <= '0;
            bit_q     <= '0;
            crc_q     <= CRC16_INIT;
            jsent_q   <= 1'b0;
            get_q     <= 1'b0;
            get_dly_q <= 1'b0;
            err_q     <= 1'b0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            left_q    <= left_d;
            bit_q     <= bit_d;
            crc_q     <= crc_d;
            jsent_q   <= jsent_d;
            get_q     <= get_d;
            get_dly_q <= get_q;
            err_q     <= err_d;
            if (get_dly_q) byte_q <= tx_packet_data;
        end
    end

    assign get_tx_packet_data = get_q;
    assign tx_transfer_active = (state_q != ST_IDLE);
    assign tx_error           = err_q;

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: directed + randomized bench for usb_tx. A behavioural model
// builds the expected per-bit line sequence (SYNC, stuffed PID/payload/CRC,
// NRZI, SE0 SE0 J) and the bench compares the lines mid-bit, plus activity
// length, fetch pulse count and buffer drain.
module tb_usb_tx;

    localparam int CPB = 8;
    localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data, tx_transfer_active, tx_error, dplus_out, dminus_out;

    int total = 0;
    int bad   = 0;
    int nget  = 0;
    int nact  = 0;

    logic [7:0] buf_q[$];
    logic [7:0] pl_q[$];
    logic [1:0] exp_q[$];

    usb_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out)
    );

    always #5 clk = ~clk;

    // Activity / fetch counters, sampled 1ns after each rising edge.
    initial forever begin
        @(posedge clk); #1;
        if (tx_transfer_active === 1'b1) nact++;
        if (get_tx_packet_data === 1'b1) nget++;
    end

    // Data buffer model: byte valid in the cycle after a fetch pulse.
    initial forever begin
        @(posedge clk); #1;
        if (get_tx_packet_data === 1'b1) begin
            @(posedge clk); #1;
            if (buf_q.size() > 0) tx_packet_data = buf_q.pop_front();
            buffer_occupancy = 7'(buf_q.size());
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] nrzi(input logic [1:0] ln, input bit b);
        return b ? ln : ((ln == LJ) ? LK : LJ);
    endfunction

    // Expected line value for every bit time of packet pkt with payload pl_q.
    task automatic build(input logic [2:0] pkt);
        logic [7:0]  syncv, pid;
        logic [15:0] r;
        bit          bq[$];
        logic [1:0]  ln;
        int          ones;
        case (pkt)
            3'd1: pid = 8'hC3;
            3'd2: pid = 8'h4B;
            3'd3: pid = 8'hD2;
            3'd4: pid = 8'h5A;
            default: pid = 8'h1E;
        endcase
        syncv = 8'h80;
        exp_q.delete();
        ln = LJ;
        for (int i = 0; i < 8; i++) begin
            ln = nrzi(ln, syncv[i]);
            exp_q.push_back(ln);
        end
        for (int i = 0; i < 8; i++) bq.push_back(pid[i]);
        if (pkt <= 3'd2) begin
            // Reflected CRC16 (0xA001), LSB-first bytes; complement sent LSB first.
            r = 16'hFFFF;
            foreach (pl_q[j]) begin
                for (int i = 0; i < 8; i++) bq.push_back(pl_q[j][i]);
                r = r ^ {8'h00, pl_q[j]};
                for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
            end
            r = ~r;
            for (int i = 0; i < 16; i++) bq.push_back(r[i]);
        end
        ones = 0;
        foreach (bq[i]) begin
            if (ones == 6) begin
                ln = nrzi(ln, 1'b0);
                exp_q.push_back(ln);
                ones = 0;
            end
            ln = nrzi(ln, bq[i]);
            exp_q.push_back(ln);
            ones = bq[i] ? ones + 1 : 0;
        end
        exp_q.push_back(LSE0);
        exp_q.push_back(LSE0);
        exp_q.push_back(LJ);
    endtask

    // Issue one command at the current (post-edge) time and check the packet.
    task automatic send(input logic [2:0] pkt, input string tag);
        int g0, a0, mism;
        build(pkt);
        if (pkt <= 3'd2) foreach (pl_q[i]) buf_q.push_back(pl_q[i]);
        buffer_occupancy = 7'(buf_q.size());
        g0 = nget;
        a0 = nact;
        mism = 0;
        tx_packet = pkt;
        @(posedge clk); #1;
        tx_packet = 3'd0;
        chk({tag, " active@E"}, tx_transfer_active, 1);
        @(posedge clk); #1;
        foreach (exp_q[i]) begin
            repeat (CPB / 2) @(posedge clk);
            #1;
            if ({dplus_out, dminus_out} !== exp_q[i]) mism++;
            repeat (CPB - CPB / 2) @(posedge clk);
            #1;
        end
        chk({tag, " line mismatches"}, mism, 0);
        chk({tag, " active low at end"}, tx_transfer_active, 0);
        chk({tag, " idle J at end"}, {dplus_out, dminus_out}, LJ);
        chk({tag, " active cycles"}, nact - a0, 1 + exp_q.size() * CPB);
        chk({tag, " fetch pulses"}, nget - g0, (pkt <= 3'd2) ? pl_q.size() : 0);
        if (pkt <= 3'd2) chk({tag, " occupancy drained"}, buffer_occupancy, 0);
    endtask

    task automatic reject(input logic [2:0] pkt, input logic [6:0] occ, input string tag);
        buffer_occupancy = occ;
        tx_packet = pkt;
        @(posedge clk); #1;
        tx_packet = 3'd0;
        chk({tag, " error pulse"}, tx_error, 1);
        chk({tag, " active stays 0"}, tx_transfer_active, 0);
        chk({tag, " lines J"}, {dplus_out, dminus_out}, LJ);
        @(posedge clk); #1;
        chk({tag, " error one cycle"}, tx_error, 0);
        chk({tag, " still idle"}, tx_transfer_active, 0);
        buffer_occupancy = 7'd0;
    endtask

    initial begin
        int g0, n;
        logic [2:0] p;
        rst = 1'b0;
        tx_packet = 3'd0;
        buffer_occupancy = 7'd0;
        tx_packet_data = 8'h00;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset lines", {dplus_out, dminus_out}, LJ);
        chk("reset active", tx_transfer_active, 0);
        chk("reset error", tx_error, 0);
        chk("reset fetch", get_tx_packet_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        pl_q.delete();
        send(3'd3, "ACK");
        send(3'd1, "DATA0 empty");
        pl_q = {8'h67, 8'h2B};
        send(3'd2, "DATA1 67 2B");
        pl_q = {8'hFF, 8'hFF};
        send(3'd1, "DATA0 FF FF");
        pl_q.delete();
        send(3'd4, "NAK");
        send(3'd5, "STALL");

        reject(3'd6, 7'd0, "cmd 6");
        reject(3'd7, 7'd0, "cmd 7");
        reject(3'd1, 7'd65, "DATA0 occ 65");

        for (int k = 0; k < 6; k++) begin
            p = 3'($urandom_range(1, 5));
            pl_q.delete();
            if (p <= 3'd2) begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
            end
            send(p, "random");
        end

        // Reset in the middle of a DATA packet.
        pl_q = {8'h12, 8'h34, 8'h56, 8'h78};
        foreach (pl_q[i]) buf_q.push_back(pl_q[i]);
        buffer_occupancy = 7'(buf_q.size());
        tx_packet = 3'd1;
        @(posedge clk); #1;
        tx_packet = 3'd0;
        repeat (30 * CPB) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid rst lines J", {dplus_out, dminus_out}, LJ);
        chk("mid rst active", tx_transfer_active, 0);
        chk("mid rst fetch", get_tx_packet_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        buf_q.delete();
        buffer_occupancy = 7'd0;
        g0 = nget;
        repeat (20 * CPB) @(posedge clk);
        #1;
        chk("post rst no fetch", nget - g0, 0);
        chk("post rst idle", tx_transfer_active, 0);
        pl_q.delete();
        send(3'd3, "ACK after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
